// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shift register: shift modes and control FSM states.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHRL = 2'b01,
    MODE_SHRA = 2'b10,
    MODE_ROL  = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_register_counter.sv
// Loadable down-counter for the shift run; last is high while the count is exactly one.
// Load and clear take effect on the next edge; decrement saturates at zero.
module shift_run_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_shift_register.sv
// Multi-mode shift register running a programmed number of 1-bit shifts, one per clock, with start/busy/done.
// Mode 11 rotates left only when SEQ_SHIFT_ROTATE_EN is defined; otherwise it behaves as SHL.
module seq_shift_register
  import seq_shift_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               CNT_W    = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic             init,
  input  logic             ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             fill,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  shift_mode_t      mode_q, mode_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shift_val;
  logic             shift_ser;
  logic             cnt_clr, cnt_load, cnt_dec, cnt_last;

  shift_run_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (amount),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // One-bit shift of the current contents using the mode and fill latched at start.
  always_comb begin
    shift_val = {q_q[WIDTH-2:0], fill_q};
    shift_ser = q_q[WIDTH-1];
    case (mode_q)
      MODE_SHRL: begin
        shift_val = {fill_q, q_q[WIDTH-1:1]};
        shift_ser = q_q[0];
      end
      MODE_SHRA: begin
        shift_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shift_ser = q_q[0];
      end
`ifdef SEQ_SHIFT_ROTATE_EN
      MODE_ROL: begin
        shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift_ser = q_q[WIDTH-1];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    q_d      = q_q;
    ser_d    = ser_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (zero || init || ld) begin
      q_d     = zero ? '0 : (init ? INIT_VAL : d_in);
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d = shift_mode_t'(mode);
            fill_d = fill;
            if (amount != '0) begin
              state_d  = ST_RUN;
              cnt_load = 1'b1;
            end else begin
              state_d = ST_FIN;
            end
          end
        end
        ST_RUN: begin
          q_d     = shift_val;
          ser_d   = shift_ser;
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_FIN;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SHL;
      fill_q  <= 1'b0;
      q_q     <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_shift_register.sv
// Directed bench for seq_shift_register (WIDTH=16) with a closed-form per-cycle reference model.
module tb_seq_shift_register;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, zero, init, ld, start, fill;
  logic [W-1:0]  d_in;
  logic [1:0]    mode;
  logic [4:0]    amount;
  logic [W-1:0]  q;
  logic          ser_out, busy, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  seq_shift_register dut (
    .clk(clk), .rst(rst), .zero(zero), .init(init), .ld(ld), .d_in(d_in),
    .start(start), .mode(mode), .amount(amount), .fill(fill),
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value after s shifts from v, computed directly from the shift rules.
  function automatic logic [W-1:0] apply(input logic [1:0] md, input logic [W-1:0] v,
                                         input logic f, input int s);
    logic [1:0] m;
    int r;
    m = md;
`ifndef SEQ_SHIFT_ROTATE_EN
    if (m == 2'b11) m = 2'b00;
`endif
    case (m)
      2'b00: begin
        if (s >= W) return {W{f}};
        return W'(v << s) | (f ? W'((32'd1 << s) - 32'd1) : W'(0));
      end
      2'b01: begin
        if (s >= W) return {W{f}};
        return W'(v >> s) | (f ? ~W'(16'hFFFF >> s) : W'(0));
      end
      2'b10: return W'($signed(v) >>> s);
      default: begin
        r = s % W;
        return W'(v << r) | W'(v >> (W - r));
      end
    endcase
  endfunction

  // Bit leaving the register on shift number j (1-based).
  function automatic logic out_bit(input logic [1:0] md, input logic [W-1:0] v,
                                   input logic f, input int j);
    logic [W-1:0] p;
    p = apply(md, v, f, j - 1);
    if (md == 2'b01 || md == 2'b10) return p[0];
    return p[W-1];
  endfunction

  // Reference model: tracks the active run by its start edge and amount.
  int           e = 0, mk = 0, mn = 0, s;
  bit           mact = 0, mvalid = 0;
  logic [1:0]   mm;
  logic         mf;
  logic [W-1:0] mq0, mq;
  logic         mser, mbusy, mdone;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      mq = '0; mser = 1'b0; mbusy = 1'b0; mdone = 1'b0; mact = 0; mvalid = 1;
    end else if (zero || init || ld) begin
      mq = zero ? W'(0) : (init ? {W{1'b1}} : d_in);
      mact = 0; mbusy = 1'b0; mdone = 1'b0;
    end else if (mact) begin
      s = e - mk;
      if (s <= mn) begin
        mq = apply(mm, mq0, mf, s);
        if (s >= 1) mser = out_bit(mm, mq0, mf, s);
        mbusy = 1'b1;
        mdone = (s == mn);
      end else begin
        mact = 0; mbusy = 1'b0; mdone = 1'b0;
      end
    end else if (start) begin
      mact = 1; mk = e; mn = int'(amount); mm = mode; mf = fill; mq0 = mq;
      mbusy = 1'b1;
      mdone = (mn == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      check("cyc_q", 32'(q), 32'(mq));
      check("cyc_ser", 32'(ser_out), 32'(mser));
      check("cyc_busy", 32'(busy), 32'(mbusy));
      check("cyc_done", 32'(done), 32'(mdone));
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic load(input logic [W-1:0] v);
    @(negedge clk); ld = 1'b1; d_in = v;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic wait_idle(output int bcyc);
    bcyc = 0;
    while (busy !== 1'b0 && bcyc < 100) begin
      bcyc++;
      @(negedge clk);
    end
    if (bcyc >= 100) begin
      tests++; fails++;
      $display("FAIL run_timeout: busy still high after %0d cycles, required idle", bcyc);
    end
  endtask

  task automatic run(input logic [1:0] md, input int amt, input logic f, output int bcyc);
    @(negedge clk); start = 1'b1; mode = md; amount = amt[4:0]; fill = f;
    @(negedge clk); start = 1'b0;
    wait_idle(bcyc);
  endtask

  int bc, d0;

  initial begin
    rst = 1'b1; zero = 1'b0; init = 1'b0; ld = 1'b0; start = 1'b0;
    fill = 1'b0; d_in = '0; mode = 2'b00; amount = '0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_ser", 32'(ser_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // 1: SHL by 4
    load(16'h00F0); d0 = done_cnt;
    run(2'b00, 4, 1'b0, bc);
    check("t1_q", 32'(q), 32'h0F00);
    check("t1_busy_cycles", 32'(bc), 32'd5);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 2: SHRA and SHRL with fill=1
    load(16'h8001); d0 = done_cnt;
    run(2'b10, 3, 1'b0, bc);
    check("t2_shra_q", 32'(q), 32'hF000);
    check("t2_shra_ser", 32'(ser_out), 32'h0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    load(16'h8001);
    run(2'b01, 3, 1'b1, bc);
    check("t2_shrl_q", 32'(q), 32'hF000);

    // 3: mode 11 by 1
    load(16'h8001);
    run(2'b11, 1, 1'b0, bc);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("t3_q", 32'(q), 32'h0003);
`else
    check("t3_q", 32'(q), 32'h0002);
`endif
    check("t3_ser", 32'(ser_out), 32'h1);

    // 4: amount 0, then ignored start during a run of 5
    d0 = done_cnt;
    run(2'b00, 0, 1'b0, bc);
    check("t4_zero_busy", 32'(bc), 32'd1);
    check("t4_zero_done", 32'(done_cnt - d0), 32'd1);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("t4_zero_q", 32'(q), 32'h0003);
`else
    check("t4_zero_q", 32'(q), 32'h0002);
`endif
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; mode = 2'b00; amount = 5'd5; fill = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; amount = 5'd1; mode = 2'b01; fill = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle(bc);
    check("t4_reissue_done", 32'(done_cnt - d0), 32'd1);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("t4_run_q", 32'(q), 32'h0060);
`else
    check("t4_run_q", 32'(q), 32'h0040);
`endif

    // Amounts beyond the width
    load(16'h8001);
    run(2'b10, 20, 1'b0, bc);
    check("big_shra_q", 32'(q), 32'hFFFF);
    check("big_shra_ser", 32'(ser_out), 32'h1);
    load(16'h1234);
    run(2'b00, 17, 1'b1, bc);
    check("big_shl_q", 32'(q), 32'hFFFF);
    check("big_shl_busy", 32'(bc), 32'd18);
    load(16'h8001);
    run(2'b11, 20, 1'b0, bc);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("big_rol_q", 32'(q), 32'h0018);
`else
    check("big_rol_q", 32'(q), 32'h0000);
`endif

    // 5: zero mid-run, init, ld beats start
    load(16'hAAAA); d0 = done_cnt;
    @(negedge clk); start = 1'b1; mode = 2'b00; amount = 5'd8; fill = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); zero = 1'b1;
    @(negedge clk); zero = 1'b0;
    check("t5_zero_q", 32'(q), 32'h0);
    check("t5_zero_busy", 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    check("t5_zero_done", 32'(done_cnt - d0), 32'd0);
    init = 1'b1;
    @(negedge clk); init = 1'b0;
    check("t5_init_q", 32'(q), 32'hFFFF);
    d0 = done_cnt;
    ld = 1'b1; d_in = 16'h1234; start = 1'b1; amount = 5'd3;
    @(negedge clk); ld = 1'b0; start = 1'b0;
    check("t5_ld_busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);
    check("t5_ld_q", 32'(q), 32'h1234);
    check("t5_ld_done", 32'(done_cnt - d0), 32'd0);

    // 6: reset mid-run, then a clean run
    load(16'hFF00);
    @(negedge clk); start = 1'b1; mode = 2'b00; amount = 5'd8; fill = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_ser", 32'(ser_out), 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_rst_q", 32'(q), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_ser", 32'(ser_out), 32'h0);
    load(16'h0001); d0 = done_cnt;
    run(2'b00, 15, 1'b0, bc);
    check("t6_run_q", 32'(q), 32'h8000);
    check("t6_run_busy", 32'(bc), 32'd16);
    check("t6_run_done", 32'(done_cnt - d0), 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
